// File: rtl/lynx_pkt_pkg.sv
// Shared packet field layout, FSM state encoding and error counter width
// for the lynx request/response traffic generators.
package lynx_pkt_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        SEND        = 2'd0,
        WAIT_CREDIT = 2'd1,
        DRAIN       = 2'd2,
        DONE        = 2'd3
    } state_e;

    // Packets are {src, dst, id[7:0], payload}, MSB first.
    function automatic int src_pos(input int w, input int aw);
        return (w - aw) + (aw - 1);
    endfunction

    function automatic int dst_pos(input int w, input int aw);
        return w - 1 - aw;
    endfunction

    function automatic int id_pos(input int w, input int aw);
        return w - 1 - 2 * aw;
    endfunction

    function automatic int payload_width(input int w, input int aw);
        return w - 2 * aw - 8;
    endfunction

endpackage

// File: rtl/req_resp_tpg_1_1_credit_tracker.sv
// In-flight request counter: +1 per request sent, -1 per reply accepted,
// with a credit flag for the next cycle and an underflow flag for stray replies.
module credit_tracker #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] outstanding,
    output logic       has_credit,
    output logic       underflow_err
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       dec_ok;

    always_comb begin
        underflow_err = dec && (cnt_q == 8'd0);
        dec_ok        = dec && !underflow_err;
        cnt_d         = cnt_q;
        if (inc && !dec_ok) begin
            cnt_d = cnt_q + 8'd1;
        end else if (!inc && dec_ok) begin
            cnt_d = cnt_q - 8'd1;
        end
        // Credit is judged on the post-update count so a freed slot is usable at once.
        has_credit = (cnt_d < 8'(MAX_OUTSTANDING));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outstanding = cnt_q;

endmodule

// File: rtl/req_resp_tpg_1_1.sv
// Closed-loop request generator: issues numbered requests round-robin over a
// destination list under a credit limit, and checks the returning replies.
module req_resp_tpg_1_1
    import lynx_pkt_pkg::*;
#(
    parameter int o0_WIDTH        = 32,
    parameter int i0_WIDTH        = 32,
    parameter int N               = 16,
    parameter int N_ADDR_WIDTH    = $clog2(N),
    parameter int NODE            = 0,
    parameter int o0_ID           = 0,
    parameter int i0_ID           = 0,
    parameter int o0_NUM_DEST     = 4,
    parameter logic [o0_NUM_DEST-1:0][N_ADDR_WIDTH-1:0] o0_DEST = {o0_NUM_DEST{N_ADDR_WIDTH'(1)}},
    parameter int MAX_OUTSTANDING = 4,
    parameter int NUM_REQS        = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    done,
    output logic [15:0]             err_count,
    output logic [o0_WIDTH-1:0]     o0_data_out,
    output logic [N_ADDR_WIDTH-1:0] o0_dest_out,
    output logic                    o0_valid_out,
    input  logic                    o0_ready_in,
    input  logic [i0_WIDTH-1:0]     i0_data_in,
    input  logic                    i0_valid_in,
    output logic                    i0_ready_out
);

    localparam int AW     = N_ADDR_WIDTH;
    localparam int PW     = payload_width(o0_WIDTH, AW);
    localparam int SRC_P  = src_pos(i0_WIDTH, AW);
    localparam int DST_P  = dst_pos(i0_WIDTH, AW);
    localparam int ID_P   = id_pos(i0_WIDTH, AW);
    localparam int CNT_W  = $clog2(NUM_REQS + 1);
    localparam int DIDX_W = (o0_NUM_DEST > 1) ? $clog2(o0_NUM_DEST) : 1;

    localparam logic [CNT_W-1:0]     NUM_REQS_C = CNT_W'(NUM_REQS);
    localparam logic [DIDX_W-1:0]    LAST_IDX   = DIDX_W'(o0_NUM_DEST - 1);
    localparam logic [AW-1:0]        NODE_C     = AW'(NODE);
    localparam logic [7:0]           ID_C       = 8'(o0_ID);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    localparam logic [1:0] S_SEND        = SEND;
    localparam logic [1:0] S_WAIT_CREDIT = WAIT_CREDIT;
    localparam logic [1:0] S_DRAIN       = DRAIN;
    localparam logic [1:0] S_DONE        = DONE;

    logic [1:0]           state_q,   state_d;
    logic                 valid_q,   valid_d;
    logic [PW-1:0]        seq_q,     seq_d;
    logic [AW-1:0]        dest_q,    dest_d;
    logic [o0_WIDTH-1:0]  data_q,    data_d;
    logic [DIDX_W-1:0]    dst_idx_q, dst_idx_d;
    logic [CNT_W-1:0]     sent_q,    sent_d;
    logic [CNT_W-1:0]     rcvd_q,    rcvd_d;
    logic [ERR_CNT_W-1:0] err_q,     err_d;
    logic                 done_q,    done_d;
    logic                 rdy_q,     rdy_d;

    logic          fire;
    logic          rsp_acc;
    logic [7:0]    outstanding;
    logic          has_credit;
    logic          underflow_err;
    logic [AW-1:0] src_f;
    logic [AW-1:0] dst_f;
    logic          src_ok;
    logic          rsp_err;
    logic          rsp_cnt;
    logic          present;
    logic [PW-1:0] seq_new;
    logic [AW-1:0] dest_new;
    logic          unused_sig;

    assign fire    = valid_q && o0_ready_in;
    assign rsp_acc = i0_valid_in && rdy_q;

    credit_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk           (clk),
        .rst           (rst),
        .inc           (fire),
        .dec           (rsp_acc),
        .outstanding   (outstanding),
        .has_credit    (has_credit),
        .underflow_err (underflow_err)
    );

    always_comb begin
        src_f  = i0_data_in[SRC_P -: AW];
        dst_f  = i0_data_in[DST_P -: AW];
        src_ok = 1'b0;
        for (int i = 0; i < o0_NUM_DEST; i++) begin
            if (o0_DEST[i] == src_f) begin
                src_ok = 1'b1;
            end
        end
        // Several faults on one reply still count as a single error.
        rsp_err = rsp_acc && (underflow_err || (dst_f != NODE_C) || !src_ok);
        rsp_cnt = rsp_acc && !underflow_err;

        sent_d    = sent_q + {{(CNT_W-1){1'b0}}, fire};
        rcvd_d    = rcvd_q + {{(CNT_W-1){1'b0}}, rsp_cnt};
        dst_idx_d = dst_idx_q;
        if (fire) begin
            dst_idx_d = (dst_idx_q == LAST_IDX) ? '0 : dst_idx_q + 1'b1;
        end
        err_d = (rsp_err && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;
        rdy_d = 1'b1;

        state_d = state_q;
        valid_d = valid_q;
        seq_d   = seq_q;
        dest_d  = dest_q;
        data_d  = data_q;
        done_d  = done_q;
        present = 1'b0;

        case (state_q)
            S_SEND: begin
                // A held beat stays untouched until it is taken.
                if (fire || !valid_q) begin
                    valid_d = 1'b0;
                    if (sent_d == NUM_REQS_C) begin
                        state_d = S_DRAIN;
                    end else if (!has_credit) begin
                        state_d = S_WAIT_CREDIT;
                    end else begin
                        present = 1'b1;
                    end
                end
            end
            S_WAIT_CREDIT: begin
                if (has_credit) begin
                    state_d = S_SEND;
                    present = 1'b1;
                end
            end
            S_DRAIN: begin
                if (rcvd_d == NUM_REQS_C) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                done_d = 1'b1;
            end
        endcase

        seq_new  = seq_q + PW'(1);
        dest_new = o0_DEST[dst_idx_d];
        if (present) begin
            valid_d = 1'b1;
            seq_d   = seq_new;
            dest_d  = dest_new;
            data_d  = {NODE_C, dest_new, ID_C, seq_new};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_SEND;
            valid_q   <= 1'b0;
            seq_q     <= '0;
            dest_q    <= '0;
            data_q    <= {NODE_C, {AW{1'b0}}, ID_C, {PW{1'b0}}};
            dst_idx_q <= '0;
            sent_q    <= '0;
            rcvd_q    <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            seq_q     <= seq_d;
            dest_q    <= dest_d;
            data_q    <= data_d;
            dst_idx_q <= dst_idx_d;
            sent_q    <= sent_d;
            rcvd_q    <= rcvd_d;
            err_q     <= err_d;
            done_q    <= done_d;
            rdy_q     <= rdy_d;
        end
    end

    assign o0_valid_out = valid_q;
    assign o0_data_out  = data_q;
    assign o0_dest_out  = dest_q;
    assign i0_ready_out = rdy_q;
    assign done         = done_q;
    assign err_count    = err_q;

    // Reply id/payload and the sink id are carried for tracing only.
    assign unused_sig = ^{i0_data_in[ID_P:0], outstanding, 8'(i0_ID)};

endmodule

// File: tb/tb_req_resp_tpg_1_1.sv
// Randomized and directed bench for req_resp_tpg_1_1 against a counter-level
// reference model of requests sent, replies received and credit in use.
module tb_req_resp_tpg_1_1;

    localparam int NUM  = 8;
    localparam int MAXO = 4;
    localparam int NODE = 0;
    localparam int ID   = 8'h5A;
    localparam int ND   = 4;
    localparam logic [ND-1:0][3:0] DEST = {4'd4, 4'd3, 4'd2, 4'd1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done;
    logic [15:0] err_count;
    logic [31:0] o0_data_out;
    logic [3:0]  o0_dest_out;
    logic        o0_valid_out;
    logic        o0_ready_in = 1'b0;
    logic [31:0] i0_data_in = '0;
    logic        i0_valid_in = 1'b0;
    logic        i0_ready_out;

    always #5 clk = ~clk;

    req_resp_tpg_1_1 #(
        .o0_WIDTH(32), .i0_WIDTH(32), .N(16), .N_ADDR_WIDTH(4),
        .NODE(NODE), .o0_ID(ID), .i0_ID(0), .o0_NUM_DEST(ND),
        .o0_DEST(DEST), .MAX_OUTSTANDING(MAXO), .NUM_REQS(NUM)
    ) dut (
        .clk(clk), .rst(rst), .done(done), .err_count(err_count),
        .o0_data_out(o0_data_out), .o0_dest_out(o0_dest_out),
        .o0_valid_out(o0_valid_out), .o0_ready_in(o0_ready_in),
        .i0_data_in(i0_data_in), .i0_valid_in(i0_valid_in),
        .i0_ready_out(i0_ready_out)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: counts since the last reset.
    int         m_sent, m_rcvd, m_out, m_err, fires;
    bit         m_rst = 1'b1;
    logic [3:0] pend[$];

    function automatic logic [3:0] dest_of(input int k);
        logic [ND-1:0][3:0] d;
        d = DEST;
        return d[k % ND];
    endfunction

    function automatic logic [31:0] beat(input int k);
        return {4'(NODE), dest_of(k - 1), 8'(ID), 16'(k)};
    endfunction

    function automatic bit in_dest(input logic [3:0] s);
        for (int i = 0; i < ND; i++) if (dest_of(i) == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mk_reply(input logic [3:0] src, input logic [3:0] dst);
        return {src, dst, 8'hC3, 16'($urandom)};
    endfunction

    task automatic tick(input logic r, input logic rdy, input logic rv, input logic [31:0] rd);
        logic        pv, pf, pa;
        logic [31:0] pdata;
        bit          hold, uf, bad, exp_v;
        rst = r; o0_ready_in = rdy; i0_valid_in = rv; i0_data_in = rd;
        pv = o0_valid_out; pdata = o0_data_out;
        pf = pv && rdy; pa = rv && i0_ready_out;
        hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (r) begin
            m_sent = 0; m_rcvd = 0; m_out = 0; m_err = 0; m_rst = 1'b1;
            pend.delete();
        end else begin
            m_rst = 1'b0;
            hold  = pv && !pf;
            uf    = pa && (m_out == 0);
            if (pa) begin
                bad = uf || (rd[27:24] != 4'(NODE)) || !in_dest(rd[31:28]);
                if (bad && m_err < 16'hFFFF) m_err++;
                if (!uf) begin m_rcvd++; m_out--; end
            end
            if (pf) begin
                pend.push_back(dest_of(m_sent));
                m_sent++; m_out++; fires++;
            end
        end
        if (m_rst) begin
            check_eq("rst_valid", o0_valid_out, 0);
            check_eq("rst_dest", o0_dest_out, 0);
            check_eq("rst_data", o0_data_out, {4'(NODE), 4'd0, 8'(ID), 16'd0});
            check_eq("rst_ready", i0_ready_out, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_err", err_count, 0);
        end else begin
            exp_v = hold || (m_sent < NUM && m_out < MAXO);
            check_eq("valid", o0_valid_out, exp_v);
            if (o0_valid_out) begin
                check_eq("data", o0_data_out, beat(m_sent + 1));
                check_eq("dest", o0_dest_out, dest_of(m_sent));
            end
            if (hold) check_eq("stable", o0_data_out, pdata);
            check_eq("ready", i0_ready_out, 1);
            check_eq("done", done, m_rcvd == NUM);
            check_eq("err", err_count, m_err);
        end
    endtask

    // One cycle with optional well-formed reply to the oldest pending request.
    task automatic step(input logic rdy, input bit reply);
        if (reply && !m_rst && pend.size() > 0)
            tick(1'b0, rdy, 1'b1, mk_reply(pend.pop_front(), 4'(NODE)));
        else
            tick(1'b0, rdy, 1'b0, $urandom);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, mk_reply(4'd1, 4'(NODE)));
        fires = 0;
    endtask

    task automatic run_loopback(input int mode, input int bound);
        logic rdy;
        for (int i = 0; i < bound && m_rcvd < NUM; i++) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (i % 4 == 0) || (i % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            step(rdy, (mode < 2) ? 1'b1 : bit'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b0);
        check_eq("done_reached", done, 1);
    endtask

    initial begin
        // Full loopback run with ready held high
        do_reset();
        run_loopback(0, 60);
        check_eq("s1_fires", fires, 8);
        check_eq("s1_err", err_count, 0);

        // Credit exhaustion, then one reply frees a slot
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        check_eq("s2_fires", fires, 4);
        check_eq("s2_valid_low", o0_valid_out, 0);
        step(1'b0, 1'b1);
        check_eq("s2_valid_back", o0_valid_out, 1);
        check_eq("s2_seq5", o0_data_out[15:0], 5);

        // Stalling ready pattern 1,0,0,1 to completion
        run_loopback(1, 200);
        check_eq("s3_fires", fires, 8);

        // Simultaneous fire and reply with three requests in flight
        do_reset();
        for (int i = 0; i < 10 && fires < 3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("s4_valid_kept", o0_valid_out, 1);
        check_eq("s4_no_err", err_count, 0);
        step(1'b1, 1'b0);
        check_eq("s4_valid_low", o0_valid_out, 0);
        check_eq("s4_fires", fires, 5);

        // Misaddressed, foreign-source and unsolicited replies
        do_reset();
        for (int i = 0; i < 10 && fires < 2; i++) step(1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, mk_reply(pend.pop_front(), 4'(NODE + 1)));
        void'(pend.pop_front());
        tick(1'b0, 1'b1, 1'b1, mk_reply(4'd9, 4'(NODE)));
        run_loopback(0, 60);
        tick(1'b0, 1'b0, 1'b1, mk_reply(4'd1, 4'(NODE)));
        check_eq("s5_err3", err_count, 3);
        check_eq("s5_done_held", done, 1);

        // Reset while a beat with seq 3 is being offered
        do_reset();
        for (int i = 0; i < 10 && !(o0_valid_out && o0_data_out[15:0] == 16'd3); i++)
            step(1'b1, 1'b1);
        check_eq("s6_seq3", o0_data_out[15:0], 3);
        tick(1'b1, 1'b1, 1'b0, '0);
        check_eq("s6_valid_dropped", o0_valid_out, 0);
        step(1'b0, 1'b0);
        check_eq("s6_seq1", o0_data_out[15:0], 1);
        check_eq("s6_dest0", o0_dest_out, 4'd1);

        // Randomized ready and reply timing
        for (int r = 0; r < 4; r++) begin
            do_reset();
            run_loopback(2, 400);
            check_eq("rand_fires", fires, 8);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
